// File: rtl/butterfly_r2_pipe.sv
// Pipelined radix-2 DIT butterfly: C1 = A + B*Wt, C2 = A - B*Wt.
// Three lock-step stages with a global advance; per-sample /2 scaling and saturation.
module butterfly_r2_pipe #(
  parameter int W  = 12,
  parameter int TW = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2*W-1:0]  A,
  input  logic [2*W-1:0]  B,
  input  logic [2*TW-1:0] Wt,
  input  logic            scale,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [2*W-1:0]  C1,
  output logic [2*W-1:0]  C2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            ovf,
  input  logic            ovf_clr
);

  localparam int PW = W + TW + 1;
  localparam int KW = W + 2;
  localparam int SW = W + 3;

  localparam logic signed [PW-1:0] RND  = PW'(2**(TW-2));
  localparam logic signed [SW-1:0] MAXV = SW'(2**(W-1) - 1);
  localparam logic signed [SW-1:0] MINV = SW'(-(2**(W-1)));

  logic            advance;

  logic            v1_q, v1_d;
  logic [2*W-1:0]  a1_q, a1_d;
  logic [2*W-1:0]  b1_q, b1_d;
  logic [2*TW-1:0] wt1_q, wt1_d;
  logic            sc1_q, sc1_d;

  logic            v2_q, v2_d;
  logic [2*W-1:0]  a2_q, a2_d;
  logic [2*KW-1:0] p2_q, p2_d;
  logic            sc2_q, sc2_d;

  logic            v3_q, v3_d;
  logic [2*W-1:0]  c1_q, c1_d;
  logic [2*W-1:0]  c2_q, c2_d;
  logic            ovf_q, ovf_d;

  logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x;
  logic signed [PW-1:0] pr_full, pi_full;
  logic [2*KW-1:0]      p_rnd;

  logic signed [SW-1:0] ar, ai, pr, pi;
  logic signed [SW-1:0] s1r, s1i, s2r, s2i;
  logic [W:0]           q1r, q1i, q2r, q2i;
  logic                 sat_any;

  // Returns {saturated_flag, clamped value}
  function automatic logic [W:0] sat_fn(input logic signed [SW-1:0] x);
    if (x > MAXV)      return {1'b1, MAXV[W-1:0]};
    else if (x < MINV) return {1'b1, MINV[W-1:0]};
    else               return {1'b0, x[W-1:0]};
  endfunction

  always_comb begin
    br_x    = PW'(signed'(b1_q[2*W-1:W]));
    bi_x    = PW'(signed'(b1_q[W-1:0]));
    wr_x    = PW'(signed'(wt1_q[2*TW-1:TW]));
    wi_x    = PW'(signed'(wt1_q[TW-1:0]));
    pr_full = br_x * wr_x - bi_x * wi_x;
    pi_full = br_x * wi_x + bi_x * wr_x;
    // Round half-up back to data scale; W+2 bits always hold the result
    p_rnd   = {KW'((pr_full + RND) >>> (TW-1)), KW'((pi_full + RND) >>> (TW-1))};
  end

  always_comb begin
    ar  = SW'(signed'(a2_q[2*W-1:W]));
    ai  = SW'(signed'(a2_q[W-1:0]));
    pr  = SW'(signed'(p2_q[2*KW-1:KW]));
    pi  = SW'(signed'(p2_q[KW-1:0]));
    s1r = ar + pr;
    s1i = ai + pi;
    s2r = ar - pr;
    s2i = ai - pi;
    if (sc2_q) begin
      s1r = s1r >>> 1;
      s1i = s1i >>> 1;
      s2r = s2r >>> 1;
      s2i = s2i >>> 1;
    end
    q1r     = sat_fn(s1r);
    q1i     = sat_fn(s1i);
    q2r     = sat_fn(s2r);
    q2i     = sat_fn(s2i);
    sat_any = q1r[W] | q1i[W] | q2r[W] | q2i[W];
  end

  always_comb begin
    advance = !v3_q || out_ready;

    v1_d  = v1_q;
    a1_d  = a1_q;
    b1_d  = b1_q;
    wt1_d = wt1_q;
    sc1_d = sc1_q;
    v2_d  = v2_q;
    a2_d  = a2_q;
    p2_d  = p2_q;
    sc2_d = sc2_q;
    v3_d  = v3_q;
    c1_d  = c1_q;
    c2_d  = c2_q;

    // All stages move together; bubbles travel with the valid bits
    if (advance) begin
      v1_d  = in_valid;
      a1_d  = A;
      b1_d  = B;
      wt1_d = Wt;
      sc1_d = scale;
      v2_d  = v1_q;
      a2_d  = a1_q;
      p2_d  = p_rnd;
      sc2_d = sc1_q;
      v3_d  = v2_q;
      c1_d  = {q1r[W-1:0], q1i[W-1:0]};
      c2_d  = {q2r[W-1:0], q2i[W-1:0]};
    end

    if (advance && v2_q && sat_any) ovf_d = 1'b1;
    else if (ovf_clr)               ovf_d = 1'b0;
    else                            ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q  <= 1'b0;
      a1_q  <= '0;
      b1_q  <= '0;
      wt1_q <= '0;
      sc1_q <= 1'b0;
      v2_q  <= 1'b0;
      a2_q  <= '0;
      p2_q  <= '0;
      sc2_q <= 1'b0;
      v3_q  <= 1'b0;
      c1_q  <= '0;
      c2_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      v1_q  <= v1_d;
      a1_q  <= a1_d;
      b1_q  <= b1_d;
      wt1_q <= wt1_d;
      sc1_q <= sc1_d;
      v2_q  <= v2_d;
      a2_q  <= a2_d;
      p2_q  <= p2_d;
      sc2_q <= sc2_d;
      v3_q  <= v3_d;
      c1_q  <= c1_d;
      c2_q  <= c2_d;
      ovf_q <= ovf_d;
    end
  end

  assign in_ready  = advance;
  assign C1        = c1_q;
  assign C2        = c2_q;
  assign out_valid = v3_q;
  assign ovf       = ovf_q;

endmodule
